// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  function automatic int feed_len(input int size);
    return 2 * size - 1;
  endfunction

  function automatic int drain_len(input int size);
    return size - 1;
  endfunction

  function automatic int idx_w(input int size);
    return $clog2(2 * size - 1);
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_counter.sv
// Phase counter with synchronous clear; tc flags the last count of an enabled phase.
module tc_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = en && (cnt_q == tc_val);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Start/done handshaked sequencer for one SIZExSIZE systolic matrix multiply:
// load, clear accumulators, feed 2*SIZE-1 skewed wavefronts, drain SIZE-1 cycles.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int SIZE  = 3,
  parameter int WIDTH = 4
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         start,
  output logic                         start_ready,
  input  logic                         abort,
  output logic                         load_en,
  output logic                         pe_clear,
  output logic                         pe_en,
  output logic                         feed_valid,
  output logic [$clog2(2*SIZE-1)-1:0]  feed_idx,
  output logic                         done,
  input  logic                         done_ack,
  output logic                         busy
);

  localparam int            IW         = idx_w(SIZE);
  localparam logic [IW-1:0] FEED_LAST  = IW'(feed_len(SIZE) - 1);
  localparam logic [IW-1:0] DRAIN_LAST = IW'(drain_len(SIZE) - 1);
  // A degenerate configuration never accepts a job.
  localparam logic          CFG_OK     = (SIZE >= 2) && (WIDTH >= 1);

  seq_state_t    state_q, state_d;
  logic          start_ready_q, pe_clear_q, pe_en_q, feed_valid_q, done_q, busy_q;
  logic          cnt_clr_s, cnt_en_s, cnt_tc_s;
  logic [IW-1:0] tc_val_s;

  // Counter runs only in FEED/DRAIN and restarts at every phase boundary or abort.
  always_comb begin
    cnt_en_s  = (state_q == FEED) || (state_q == DRAIN);
    tc_val_s  = (state_q == FEED) ? FEED_LAST : DRAIN_LAST;
    cnt_clr_s = !cnt_en_s || cnt_tc_s || abort;
  end

  tc_counter #(.W(IW)) u_phase_cnt (
    .clock  (clock),
    .nreset (nreset),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .tc_val (tc_val_s),
    .cnt    (feed_idx),
    .tc     (cnt_tc_s)
  );

  // Next-state decode; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && CFG_OK) state_d = CLEAR; else state_d = IDLE;
      CLEAR:   if (abort) state_d = IDLE; else state_d = FEED;
      FEED:    if (abort) state_d = IDLE; else if (cnt_tc_s) state_d = DRAIN; else state_d = FEED;
      DRAIN:   if (abort) state_d = IDLE; else if (cnt_tc_s) state_d = DONE; else state_d = DRAIN;
      DONE:    if (done_ack) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State register with outputs decoded from the next state so they come from flops.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q       <= IDLE;
      start_ready_q <= 1'b1;
      pe_clear_q    <= 1'b0;
      pe_en_q       <= 1'b0;
      feed_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_ready_q <= (state_d == IDLE);
      pe_clear_q    <= (state_d == CLEAR);
      pe_en_q       <= (state_d == FEED) || (state_d == DRAIN);
      feed_valid_q  <= (state_d == FEED);
      done_q        <= (state_d == DONE);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign load_en     = start && nreset && (state_q == IDLE) && CFG_OK;
  assign start_ready = start_ready_q;
  assign pe_clear    = pe_clear_q;
  assign pe_en       = pe_en_q;
  assign feed_valid  = feed_valid_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule
